// File: rtl/multicycle_controller_if.sv
// Control bundle between instruction-register decode / multi-cycle datapath and the controller.
// The controller binds to the slave modport; the decode/datapath side uses master.
interface multicycle_controller_if #(
   parameter int OP_W   = 5,
   parameter int F5_W   = 5,
   parameter int ALUC_W = 4,
   parameter int CNT_W  = 16
);
   logic [OP_W-1:0]   op;
   logic [F5_W-1:0]   funct5;
   logic              f7b5;
   logic              zero;
   logic              mem_ready;
   logic              mem_req;
   logic              memwrite;
   logic              adrsrc;
   logic              irwrite;
   logic              pcwrite;
   logic              regwrite;
   logic [1:0]        resultsrc;
   logic [1:0]        alusrca;
   logic [1:0]        alusrcb;
   logic [1:0]        immsrc;
   logic [ALUC_W-1:0] alucontrol;
   logic              halted;
   logic              fault;
   logic [CNT_W-1:0]  instret;

   modport master (
      output op, funct5, f7b5, zero, mem_ready,
      input  mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite, resultsrc,
             alusrca, alusrcb, immsrc, alucontrol, halted, fault, instret
   );

   modport slave (
      input  op, funct5, f7b5, zero, mem_ready,
      output mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite, resultsrc,
             alusrca, alusrcb, immsrc, alucontrol, halted, fault, instret
   );
endinterface

// File: rtl/multicycle_controller.sv
// Moore controller for the multi-cycle 19-bit CPU: sequences fetch/decode/execute/memory/
// writeback, handshakes with a shared memory (with timeout), traps illegal opcodes, counts retirement.
module multicycle_controller #(
   parameter int OP_W        = 5,
   parameter int F5_W        = 5,
   parameter int ALUC_W      = 4,
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   reset_n,
   multicycle_controller_if.slave bus
);

   localparam logic [OP_W-1:0] OP_R     = OP_W'(5'b00000);
   localparam logic [OP_W-1:0] OP_I     = OP_W'(5'b00001);
   localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(5'b00010);
   localparam logic [OP_W-1:0] OP_STORE = OP_W'(5'b00011);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5'b00100);
   localparam logic [OP_W-1:0] OP_BNE   = OP_W'(5'b00101);
   localparam logic [OP_W-1:0] OP_JAL   = OP_W'(5'b00110);
   localparam logic [OP_W-1:0] OP_HALT  = OP_W'(5'b11111);
   localparam logic [F5_W-1:0] F5_ZERO  = '0;

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   typedef enum logic [3:0] {
      ST_IDLE, ST_FETCH, ST_DECODE, ST_MEMADR, ST_MEMREAD, ST_MEMWB, ST_MEMWRITE,
      ST_EXECR, ST_EXECI, ST_ALUWB, ST_BRANCH, ST_JAL, ST_HALT, ST_FAULT
   } state_e;

   typedef struct packed {
      logic       mem_req;
      logic       memwrite;
      logic       adrsrc;
      logic       regwrite;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic       halted;
      logic       fault;
   } ctrl_t;

   state_e            state_q, state_d;
   ctrl_t             ctrl_q;
   logic [WAIT_W-1:0] wait_q;
   logic [CNT_W-1:0]  instret_q;
   logic              mem_wait;
   logic              timeout_hit;
   logic              retire;
   logic              branch_taken;
   logic [1:0]        immsrc_d;
   logic [ALUC_W-1:0] alucontrol_d;

   // Moore control word of a state; registered from the next state so it lines up with state_q.
   function automatic ctrl_t moore_ctrl(state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         ST_FETCH:    begin c.mem_req = 1'b1; c.alusrcb = 2'b10; c.resultsrc = 2'b10; end
         ST_DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b01; end
         ST_MEMADR:   begin c.alusrca = 2'b10; c.alusrcb = 2'b01; end
         ST_MEMREAD:  begin c.mem_req = 1'b1; c.adrsrc = 1'b1; end
         ST_MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
         ST_MEMWRITE: begin c.mem_req = 1'b1; c.adrsrc = 1'b1; c.memwrite = 1'b1; end
         ST_EXECR:    begin c.alusrca = 2'b10; c.alusrcb = 2'b00; c.aluop = 2'b10; end
         ST_EXECI:    begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.aluop = 2'b10; end
         ST_ALUWB:    c.regwrite = 1'b1;
         ST_BRANCH:   begin c.alusrca = 2'b10; c.alusrcb = 2'b00; c.aluop = 2'b01; end
         ST_JAL:      begin c.alusrca = 2'b01; c.alusrcb = 2'b10; end
         ST_HALT:     c.halted = 1'b1;
         ST_FAULT:    c.fault = 1'b1;
         default:     ;
      endcase
      return c;
   endfunction

   assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_q == WAIT_LAST);

   always_comb begin
      // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
      state_d  = state_q;
      mem_wait = 1'b0;
      case (state_q)
         ST_IDLE:  state_d = ST_FETCH;
         ST_FETCH: begin
            mem_wait = 1'b1;
            if (bus.mem_ready) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            case (bus.op)
               OP_LOAD, OP_STORE: state_d = ST_MEMADR;
               OP_R:              state_d = ST_EXECR;
               OP_I:              state_d = ST_EXECI;
               OP_BEQ, OP_BNE:    state_d = ST_BRANCH;
               OP_JAL:            state_d = ST_JAL;
               OP_HALT:           state_d = ST_HALT;
               default:           state_d = ST_FAULT;
            endcase
         end
         ST_MEMADR: state_d = (bus.op == OP_STORE) ? ST_MEMWRITE : ST_MEMREAD;
         ST_MEMREAD: begin
            mem_wait = 1'b1;
            if (bus.mem_ready) state_d = ST_MEMWB;
         end
         ST_MEMWRITE: begin
            mem_wait = 1'b1;
            if (bus.mem_ready) state_d = ST_FETCH;
         end
         ST_EXECR, ST_EXECI, ST_JAL:      state_d = ST_ALUWB;
         ST_MEMWB, ST_ALUWB, ST_BRANCH:   state_d = ST_FETCH;
         default:                         ;
      endcase
      // A ready on the last allowed cycle still completes the access.
      if (mem_wait && !bus.mem_ready && timeout_hit) state_d = ST_FAULT;
   end

   assign retire = (state_d == ST_FETCH) &&
                   (state_q inside {ST_MEMWB, ST_MEMWRITE, ST_ALUWB, ST_BRANCH});

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         ctrl_q    <= '0;
         wait_q    <= '0;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= moore_ctrl(state_d);
         wait_q  <= (mem_wait && !bus.mem_ready && (state_d == state_q)) ? wait_q + 1'b1 : '0;
         if (retire && !(&instret_q)) instret_q <= instret_q + 1'b1;
      end
   end

   assign branch_taken = (bus.op == OP_BNE) ? !bus.zero : bus.zero;

   always_comb begin
      immsrc_d = 2'b00;
      if (state_q != ST_IDLE) begin
         case (bus.op)
            OP_STORE:       immsrc_d = 2'b01;
            OP_BEQ, OP_BNE: immsrc_d = 2'b10;
            OP_JAL:         immsrc_d = 2'b11;
            default:        immsrc_d = 2'b00;
         endcase
      end
   end

   always_comb begin
      alucontrol_d = '0;
      case (ctrl_q.aluop)
         2'b01: alucontrol_d = ALUC_W'(1);
         2'b10: begin
            if (bus.op == OP_R && bus.funct5 == F5_ZERO && bus.f7b5) alucontrol_d = ALUC_W'(1);
            else                                                     alucontrol_d = ALUC_W'(bus.funct5);
         end
         default: alucontrol_d = '0;
      endcase
   end

   assign bus.mem_req    = ctrl_q.mem_req;
   assign bus.memwrite   = ctrl_q.memwrite;
   assign bus.adrsrc     = ctrl_q.adrsrc;
   assign bus.regwrite   = ctrl_q.regwrite;
   assign bus.resultsrc  = ctrl_q.resultsrc;
   assign bus.alusrca    = ctrl_q.alusrca;
   assign bus.alusrcb    = ctrl_q.alusrcb;
   assign bus.halted     = ctrl_q.halted;
   assign bus.fault      = ctrl_q.fault;
   assign bus.irwrite    = (state_q == ST_FETCH) && bus.mem_ready;
   assign bus.pcwrite    = ((state_q == ST_FETCH) && bus.mem_ready) || (state_q == ST_JAL) ||
                           ((state_q == ST_BRANCH) && branch_taken);
   assign bus.immsrc     = immsrc_d;
   assign bus.alucontrol = alucontrol_d;
   assign bus.instret    = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-instruction step model with randomized
// handshake timing, branch flags and opcode mix; narrow counter so saturation is reachable.
module tb_multicycle_controller;
   localparam int CNT_W       = 4;
   localparam int MEM_TIMEOUT = 4;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   localparam logic [4:0] OP_R     = 5'b00000;
   localparam logic [4:0] OP_I     = 5'b00001;
   localparam logic [4:0] OP_LOAD  = 5'b00010;
   localparam logic [4:0] OP_STORE = 5'b00011;
   localparam logic [4:0] OP_BEQ   = 5'b00100;
   localparam logic [4:0] OP_BNE   = 5'b00101;
   localparam logic [4:0] OP_JAL   = 5'b00110;
   localparam logic [4:0] OP_HALT  = 5'b11111;

   typedef enum {
      S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
      S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_HALT, S_FAULT
   } step_e;

   typedef struct packed {
      logic       mem_req;
      logic       memwrite;
      logic       adrsrc;
      logic       irwrite;
      logic       pcwrite;
      logic       regwrite;
      logic [1:0] resultsrc;
      logic [1:0] alusrca;
      logic [1:0] alusrcb;
      logic [1:0] immsrc;
      logic [3:0] alucontrol;
      logic       halted;
      logic       fault;
   } ctrl_t;

   logic  clk = 1'b0;
   logic  reset_n = 1'b0;
   int    errors = 0;
   int    checks = 0;
   int    exp_instret = 0;
   string cur_test = "init";

   multicycle_controller_if #(.CNT_W(CNT_W)) bus ();

   multicycle_controller #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   always #5 clk = ~clk;

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic ctrl_t sample();
      ctrl_t c;
      c.mem_req = bus.mem_req;     c.memwrite = bus.memwrite;     c.adrsrc = bus.adrsrc;
      c.irwrite = bus.irwrite;     c.pcwrite = bus.pcwrite;       c.regwrite = bus.regwrite;
      c.resultsrc = bus.resultsrc; c.alusrca = bus.alusrca;       c.alusrcb = bus.alusrcb;
      c.immsrc = bus.immsrc;       c.alucontrol = bus.alucontrol; c.halted = bus.halted;
      c.fault = bus.fault;
      return c;
   endfunction

   // Expected control outputs for one cycle spent in a given step of an instruction.
   function automatic ctrl_t expect_ctrl(step_e s, logic [4:0] op, logic [4:0] f5, logic f7,
                                         logic z, logic ready);
      ctrl_t      c;
      logic [3:0] func_alu;
      c = '0;
      func_alu = (op == OP_R && f5 == 5'd0 && f7) ? 4'b0001 : f5[3:0];
      if (s != S_IDLE) begin
         if (op == OP_STORE)                    c.immsrc = 2'b01;
         else if (op == OP_BEQ || op == OP_BNE) c.immsrc = 2'b10;
         else if (op == OP_JAL)                 c.immsrc = 2'b11;
      end
      case (s)
         S_FETCH:    begin c.mem_req = 1; c.alusrcb = 2; c.resultsrc = 2;
                           c.irwrite = ready; c.pcwrite = ready; end
         S_DECODE:   begin c.alusrca = 1; c.alusrcb = 1; end
         S_MEMADR:   begin c.alusrca = 2; c.alusrcb = 1; end
         S_MEMREAD:  begin c.mem_req = 1; c.adrsrc = 1; end
         S_MEMWB:    begin c.resultsrc = 1; c.regwrite = 1; end
         S_MEMWRITE: begin c.mem_req = 1; c.adrsrc = 1; c.memwrite = 1; end
         S_EXECR:    begin c.alusrca = 2; c.alusrcb = 0; c.alucontrol = func_alu; end
         S_EXECI:    begin c.alusrca = 2; c.alusrcb = 1; c.alucontrol = func_alu; end
         S_ALUWB:    c.regwrite = 1;
         S_BRANCH:   begin c.alusrca = 2; c.alucontrol = 4'b0001;
                           c.pcwrite = (op == OP_BNE) ? !z : z; end
         S_JAL:      begin c.alusrca = 1; c.alusrcb = 2; c.pcwrite = 1; end
         S_HALT:     c.halted = 1;
         S_FAULT:    c.fault = 1;
         default:    ;
      endcase
      return c;
   endfunction

   // One clock cycle in step s: drive mem_ready, compare mid-cycle, advance to posedge+1.
   task automatic drive_cycle(step_e s, logic ready);
      ctrl_t got, exp;
      bus.mem_ready = ready;
      #1;
      exp = expect_ctrl(s, bus.op, bus.funct5, bus.f7b5, bus.zero, ready);
      got = sample();
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s/%s got=%h expected=%h", cur_test, s.name(), got, exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic mem_phase(step_e s, int waits);
      repeat (waits) drive_cycle(s, 1'b0);
      drive_cycle(s, 1'b1);
   endtask

   task automatic retire_one();
      if (exp_instret < CNT_MAX) exp_instret++;
   endtask

   // Runs one instruction from its first FETCH cycle; terminal ops stay put for a few cycles.
   task automatic run_instr(logic [4:0] op, logic [4:0] f5, logic f7, logic z, int wf, int wm);
      bus.op = op; bus.funct5 = f5; bus.f7b5 = f7; bus.zero = z;
      checks++;
      if (bus.instret !== CNT_W'(exp_instret)) begin
         errors++;
         $display("FAIL %s/instret got=%0d expected=%0d", cur_test, bus.instret, exp_instret);
      end
      mem_phase(S_FETCH, wf);
      drive_cycle(S_DECODE, rbit());
      case (op)
         OP_R:     begin drive_cycle(S_EXECR, rbit()); drive_cycle(S_ALUWB, rbit()); retire_one(); end
         OP_I:     begin drive_cycle(S_EXECI, rbit()); drive_cycle(S_ALUWB, rbit()); retire_one(); end
         OP_LOAD:  begin drive_cycle(S_MEMADR, rbit()); mem_phase(S_MEMREAD, wm);
                         drive_cycle(S_MEMWB, rbit()); retire_one(); end
         OP_STORE: begin drive_cycle(S_MEMADR, rbit()); mem_phase(S_MEMWRITE, wm); retire_one(); end
         OP_BEQ, OP_BNE: begin drive_cycle(S_BRANCH, rbit()); retire_one(); end
         OP_JAL:   begin drive_cycle(S_JAL, rbit()); drive_cycle(S_ALUWB, rbit()); retire_one(); end
         OP_HALT:  repeat (4) drive_cycle(S_HALT, rbit());
         default:  repeat (4) drive_cycle(S_FAULT, rbit());
      endcase
   endtask

   // Asserts reset wherever the FSM is, checks outputs clear asynchronously, then checks IDLE.
   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      checks++;
      if (sample() !== ctrl_t'(0) || bus.instret !== '0) begin
         errors++;
         $display("FAIL %s/async_reset got=%h instret=%0d expected=0", cur_test, sample(), bus.instret);
      end
      exp_instret = 0;
      @(negedge clk);
      reset_n = 1'b1;
      drive_cycle(S_IDLE, rbit());
   endtask

   task automatic test_reset();
      cur_test = "reset";
      bus.op = OP_R; bus.funct5 = '0; bus.f7b5 = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
      #3;
      do_reset();
   endtask

   task automatic test_rtype_sub();
      cur_test = "rtype_sub";
      run_instr(OP_R, 5'd0, 1'b1, 1'b0, 0, 0);
      run_instr(OP_R, 5'b10110, 1'b1, 1'b0, 0, 0);
   endtask

   task automatic test_load_wait();
      cur_test = "load_wait";
      run_instr(OP_LOAD, 5'd0, 1'b0, 1'b0, 0, 3);
   endtask

   task automatic test_branch();
      cur_test = "branch";
      run_instr(OP_BNE, 5'd0, 1'b0, 1'b1, 0, 0);
      run_instr(OP_BNE, 5'd0, 1'b0, 1'b0, 0, 0);
      run_instr(OP_BEQ, 5'd0, 1'b0, 1'b1, 0, 0);
      run_instr(OP_BEQ, 5'd0, 1'b0, 1'b0, 3, 0);
   endtask

   task automatic test_jal();
      cur_test = "jal";
      run_instr(OP_JAL, 5'd3, 1'b0, 1'b0, 1, 0);
   endtask

   task automatic test_back_to_back();
      logic [4:0] ops [7] = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BEQ, OP_BNE, OP_JAL};
      cur_test = "back_to_back";
      for (int i = 0; i < 24; i++) begin
         run_instr(ops[$urandom_range(0, 6)], 5'($urandom), rbit(), rbit(),
                   $urandom_range(0, MEM_TIMEOUT - 1), $urandom_range(0, MEM_TIMEOUT - 1));
      end
      checks++;
      if (bus.instret !== CNT_W'(CNT_MAX) || exp_instret != CNT_MAX) begin
         errors++;
         $display("FAIL %s/saturate got=%0d expected=%0d", cur_test, bus.instret, CNT_MAX);
      end
   endtask

   task automatic test_halt();
      cur_test = "halt";
      run_instr(OP_HALT, 5'd0, 1'b0, 1'b0, 0, 0);
      checks++;
      if (bus.instret !== CNT_W'(exp_instret)) begin
         errors++;
         $display("FAIL %s/instret_frozen got=%0d expected=%0d", cur_test, bus.instret, exp_instret);
      end
   endtask

   task automatic test_illegal();
      cur_test = "illegal";
      do_reset();
      run_instr(5'b01010, 5'd0, 1'b0, 1'b0, 0, 0);
      do_reset();
      run_instr(5'b10000, 5'd1, 1'b1, 1'b1, 2, 0);
   endtask

   task automatic test_timeout();
      cur_test = "timeout";
      do_reset();
      bus.op = OP_R;
      repeat (MEM_TIMEOUT) drive_cycle(S_FETCH, 1'b0);
      repeat (4) drive_cycle(S_FAULT, 1'b1);
      cur_test = "timeout_memread";
      do_reset();
      bus.op = OP_LOAD;
      drive_cycle(S_FETCH, 1'b1);
      drive_cycle(S_DECODE, 1'b0);
      drive_cycle(S_MEMADR, 1'b0);
      repeat (MEM_TIMEOUT) drive_cycle(S_MEMREAD, 1'b0);
      drive_cycle(S_FAULT, 1'b1);
      checks++;
      if (bus.instret !== '0) begin
         errors++;
         $display("FAIL %s/instret got=%0d expected=0", cur_test, bus.instret);
      end
   endtask

   task automatic test_reset_mid_write();
      cur_test = "reset_mid_write";
      do_reset();
      bus.op = OP_STORE;
      drive_cycle(S_FETCH, 1'b1);
      drive_cycle(S_DECODE, 1'b0);
      drive_cycle(S_MEMADR, 1'b0);
      drive_cycle(S_MEMWRITE, 1'b0);
      do_reset();
      run_instr(OP_STORE, 5'd0, 1'b0, 1'b0, 0, 1);
      run_instr(OP_I, 5'b01101, 1'b1, 1'b0, 0, 0);
   endtask

   initial begin
      test_reset();
      test_rtype_sub();
      test_load_wait();
      test_branch();
      test_jal();
      test_back_to_back();
      test_halt();
      test_illegal();
      test_timeout();
      test_reset_mid_write();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle controller of the 19-bit CPU.
- Moore FSM sequences fetch/decode/execute/memory/writeback over several cycles. This lets one ALU and one unified memory be shared.
- Adds over the single-cycle controller: a memory request/ready handshake with a timeout, a HALT state, illegal-opcode trapping, BNE, and a retired-instruction counter.
- Sits between instruction register decode and the multi-cycle datapath.

Parameters:
- OP_W, 5, opcode width.
- F5_W, 5, funct5 width.
- ALUC_W, 4, alucontrol width.
- CNT_W, 16, width of the retired-instruction counter.
- MEM_TIMEOUT, 64, maximum wait cycles for mem_ready; 0 disables the timeout.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- op  in  OP_W  opcode from instruction register.
- funct5  in  F5_W  function field.
- f7b5  in  1  subtract-select bit.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- memwrite  out  1  write strobe.
- adrsrc  out  1  0=PC, 1=ALUOut.
- irwrite  out  1  load instruction register.
- pcwrite  out  1  PC update.
- regwrite  out  1  register file write.
- resultsrc  out  2  00=ALUOut, 01=memory data, 10=ALU result.
- alusrca  out  2  00=PC, 01=oldPC, 10=rs1.
- alusrcb  out  2  00=rs2, 01=imm, 10=constant 1.
- immsrc  out  2  immediate format.
- alucontrol  out  ALUC_W  ALU operation.
- halted  out  1  HALT state reached.
- fault  out  1  illegal opcode or memory timeout.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- **Opcodes:**
  - 00000 R-type, 00001 I-type ALU.
  - 00010 load, 00011 store.
  - 00100 beq, 00101 bne.
  - 00110 jal, 11111 halt.
  - All other opcodes are illegal.
- **Reset:** asynchronous to state IDLE. Every output is 0, instret=0, wait counter=0. IDLE goes to FETCH unconditionally on the next edge.
- **Outputs:** decoded from state only, except pcwrite in BRANCH and the mem_ready-qualified strobes. Unlisted outputs are 0 in each state.
- **immsrc:** combinational from op. I-type/load=00, store=01, branch=10, jal=11, otherwise 00.
- **aluop (internal):**
  - 00 gives add (0000); 01 gives sub (0001).
  - 10 gives funct5[3:0], except R-type with funct5=0 and f7b5=1, which gives 0001.
- **FETCH:**
  - mem_req=1, adrsrc=0, alusrca=00, alusrcb=10, add, resultsrc=10.
  - irwrite=pcwrite=mem_ready.
  - Stays in FETCH until mem_ready, then DECODE.
- **DECODE:** alusrca=01, alusrcb=01, add. Next state:
  - load/store: MEMADR.
  - R-type: EXECR; I-type: EXECI.
  - beq/bne: BRANCH; jal: JAL.
  - halt: HALT; illegal: FAULT.
- **MEMADR:** alusrca=10, alusrcb=01, add. Load goes to MEMREAD, store to MEMWRITE.
- **MEMREAD:** mem_req=1, adrsrc=1. Waits for mem_ready, then MEMWB.
- **MEMWB:** resultsrc=01, regwrite=1, then FETCH.
- **MEMWRITE:** mem_req=1, adrsrc=1, memwrite=1. Waits for mem_ready, then FETCH.
- **EXECR:** alusrca=10, alusrcb=00, aluop=10, then ALUWB.
- **EXECI:** alusrca=10, alusrcb=01, aluop=10, then ALUWB.
- **ALUWB:** resultsrc=00, regwrite=1, then FETCH.
- **BRANCH:** alusrca=10, alusrcb=00, sub, resultsrc=00. pcwrite=zero for beq, ~zero for bne. Then FETCH.
- **JAL:** alusrca=01, alusrcb=10, add, resultsrc=00, pcwrite=1, then ALUWB (writes oldPC+1).
- **HALT:** halted=1; terminal until reset.
- **FAULT:** fault=1; terminal until reset.
- **Wait counter:**
  - Increments each cycle in FETCH/MEMREAD/MEMWRITE while mem_ready=0.
  - Clears on mem_ready or on state exit.
  - When MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT-1 with mem_ready still 0, the next state is FAULT. mem_req drops in FAULT.
  - mem_ready on that same cycle wins: the access completes normally.
- **instret:**
  - Increments by 1 on transitions into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH; never on IDLE→FETCH.
  - Saturates at all-ones.
- **Reset mid-operation:** mid-wait or mid-instruction, reset returns to IDLE immediately; no write strobe survives.

Test Plan:
- Reset, mem_ready tied 1, op=00000, funct5=0, f7b5=1 → IDLE, FETCH, DECODE, EXECR (alucontrol=0001), ALUWB (regwrite=1), FETCH; instret=1.
- Load, mem_ready=0 for 3 cycles in MEMREAD → mem_req held 4 cycles; MEMWB resultsrc=01; 5 states plus waits; instret=1.
- bne with zero=1 → pcwrite=0 in BRANCH; repeat with zero=0 → pcwrite=1; beq mirrors this.
- jal → JAL (pcwrite=1), ALUWB (regwrite=1, resultsrc=00); immsrc=11 throughout.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH → FAULT after 4 FETCH cycles, fault=1, mem_req=0, stays until reset_n low.
- op=01010 → FAULT; op=11111 → halted=1; instret frozen; reset_n pulse mid-MEMWRITE → outputs 0 asynchronously.
